// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
// Holds the bus width, memory size, the DMEM access-size encodings and a
// helper that turns an access-size code into a byte count.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DMEM_SIZE  = 1024;

    // mem_read[1:0] size code; mem_read[MEM_RD_SIGN] selects sign extension
    localparam logic [1:0] MEM_RD_NONE = 2'b00;
    localparam logic [1:0] MEM_RD_BYTE = 2'b01;
    localparam logic [1:0] MEM_RD_HALF = 2'b10;
    localparam logic [1:0] MEM_RD_WORD = 2'b11;
    localparam int unsigned MEM_RD_SIGN = 2;

    localparam logic [1:0] MEM_WR_NONE = 2'b00;
    localparam logic [1:0] MEM_WR_BYTE = 2'b01;
    localparam logic [1:0] MEM_WR_HALF = 2'b10;
    localparam logic [1:0] MEM_WR_WORD = 2'b11;

    typedef enum logic [1:0] {
        WinNone,
        WinCore,
        WinDbg
    } winner_e;

    // Number of bytes touched by a size code (read and write codes match).
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            MEM_RD_BYTE: n = 3'd1;
            MEM_RD_HALF: n = 3'd2;
            MEM_RD_WORD: n = 3'd4;
            default:     n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side data-memory bus.
// master: the requester (drives req/addr/wdata/mem_read/mem_write,
//         receives gnt/rvalid/rdata/err).
// slave:  the arbiter (the opposite directions).
interface dmem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  req;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            mem_read;
    logic [1:0]            mem_write;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, addr, wdata, mem_read, mem_write,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, wdata, mem_read, mem_write,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_req_check.sv
// Combinational legality check for one data-memory request.
// Ports:
//   addr, mem_read, mem_write : request under test
//   err    : misaligned, out of range, or read and write at once
//   rd_ok  : legal read (safe to forward to DMEM)
//   wr_ok  : legal write (safe to forward to DMEM)
module dmem_req_check #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DMEM_SIZE  = 1024
) (
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [2:0]            mem_read,
    input  logic [1:0]            mem_write,
    output logic                  err,
    output logic                  rd_ok,
    output logic                  wr_ok
);
    import dmem_arbiter_pkg::*;

    logic              rd_act;
    logic              wr_act;
    logic [1:0]        size;
    logic              misaligned;
    logic              out_of_range;
    logic              conflict;
    logic [DATA_WIDTH:0] end_addr;

    always_comb begin
        rd_act = mem_read[1:0] != MEM_RD_NONE;
        wr_act = mem_write != MEM_WR_NONE;
        size   = rd_act ? mem_read[1:0] : mem_write;

        misaligned = ((size == MEM_RD_HALF) && addr[0]) ||
                     ((size == MEM_RD_WORD) && (addr[1:0] != 2'b00));

        // One extra bit so addresses near the top of the space cannot wrap.
        end_addr     = {1'b0, addr} + {{(DATA_WIDTH - 2){1'b0}}, access_bytes(size)};
        out_of_range = end_addr > (DATA_WIDTH + 1)'(DMEM_SIZE);

        conflict = (mem_read != 3'b000) && wr_act;

        // A no-op request touches nothing, so only real accesses can fault.
        err   = ((rd_act || wr_act) && (misaligned || out_of_range)) || conflict;
        rd_ok = rd_act && !err;
        wr_ok = wr_act && !err;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-way arbiter in front of the single data-memory port.
// Core has priority; dbg is forced through after STARVE_LIMIT consecutive
// denied cycles. The winner's request is checked, forwarded combinationally
// to DMEM, and its response (rvalid/rdata/err) is registered one cycle later.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   core, dbg       : requester buses (slave side)
//   mem_addr, mem_write_data, mem_mem_read, mem_mem_write : to DMEM
//   mem_read_data   : combinational DMEM read data
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DMEM_SIZE    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         core,
    dmem_arbiter_if.slave         dbg,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [2:0]            mem_mem_read,
    output logic [1:0]            mem_mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    import dmem_arbiter_pkg::*;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    winner_e               winner;
    logic [3:0]            starve_q, starve_d;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_rd;
    logic [1:0]            sel_wr;
    logic                  chk_err;
    logic                  chk_rd_ok;
    logic                  chk_wr_ok;

    logic                  core_rvalid_q, dbg_rvalid_q;
    logic                  core_err_q, dbg_err_q;
    logic [DATA_WIDTH-1:0] core_rdata_q, dbg_rdata_q;

    // Arbitration and winner mux
    always_comb begin
        winner    = WinNone;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 3'b000;
        sel_wr    = 2'b00;

        if (dbg.req && (!core.req || (starve_q == StarveMax))) begin
            winner = WinDbg;
        end else if (core.req) begin
            winner = WinCore;
        end

        unique case (winner)
            WinCore: begin
                sel_addr  = core.addr;
                sel_wdata = core.wdata;
                sel_rd    = core.mem_read;
                sel_wr    = core.mem_write;
            end
            WinDbg: begin
                sel_addr  = dbg.addr;
                sel_wdata = dbg.wdata;
                sel_rd    = dbg.mem_read;
                sel_wr    = dbg.mem_write;
            end
            default: ;
        endcase
    end

    dmem_req_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .DMEM_SIZE  (DMEM_SIZE)
    ) u_check (
        .addr      (sel_addr),
        .mem_read  (sel_rd),
        .mem_write (sel_wr),
        .err       (chk_err),
        .rd_ok     (chk_rd_ok),
        .wr_ok     (chk_wr_ok)
    );

    // Illegal requests are still granted but must not touch DMEM.
    always_comb begin
        mem_addr       = sel_addr;
        mem_write_data = sel_wdata;
        mem_mem_read   = chk_rd_ok ? sel_rd : 3'b000;
        mem_mem_write  = chk_wr_ok ? sel_wr : 2'b00;
    end

    assign core.gnt = (winner == WinCore);
    assign dbg.gnt  = (winner == WinDbg);

    // Count cycles dbg waits behind core; any other outcome clears it.
    always_comb begin
        starve_d = 4'd0;
        if ((winner == WinCore) && dbg.req) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q      <= 4'd0;
            core_rvalid_q <= 1'b0;
            core_err_q    <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rvalid_q  <= 1'b0;
            dbg_err_q     <= 1'b0;
            dbg_rdata_q   <= '0;
        end else begin
            starve_q      <= starve_d;
            core_rvalid_q <= (winner == WinCore) && chk_rd_ok;
            core_err_q    <= (winner == WinCore) && chk_err;
            dbg_rvalid_q  <= (winner == WinDbg) && chk_rd_ok;
            dbg_err_q     <= (winner == WinDbg) && chk_err;
            if ((winner == WinCore) && chk_rd_ok) begin
                core_rdata_q <= mem_read_data;
            end
            if ((winner == WinDbg) && chk_rd_ok) begin
                dbg_rdata_q <= mem_read_data;
            end
        end
    end

    assign core.rvalid = core_rvalid_q;
    assign core.err    = core_err_q;
    assign core.rdata  = core_rdata_q;
    assign dbg.rvalid  = dbg_rvalid_q;
    assign dbg.err     = dbg_err_q;
    assign dbg.rdata   = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-array DMEM model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(32)) core_bus ();
    dmem_arbiter_if #(.DATA_WIDTH(32)) dbg_bus ();

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_mem_read;
    logic [1:0]  mem_mem_write;
    logic [31:0] mem_read_data;

    dmem_arbiter #(
        .DATA_WIDTH   (32),
        .DMEM_SIZE    (1024),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core           (core_bus),
        .dbg            (dbg_bus),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_read_data  (mem_read_data)
    );

    // DMEM model: little-endian bytes, combinational read, write on posedge.
    logic [7:0] dmem [0:1023];
    logic [9:0] ra;
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        ra  = mem_addr[9:0];
        rb0 = dmem[ra];
        rb1 = dmem[ra + 10'd1];
        rb2 = dmem[ra + 10'd2];
        rb3 = dmem[ra + 10'd3];
        mem_read_data = 32'h0;
        case (mem_mem_read[1:0])
            2'b01: mem_read_data = mem_mem_read[2] ? {{24{rb0[7]}}, rb0} : {24'h0, rb0};
            2'b10: mem_read_data = mem_mem_read[2] ? {{16{rb1[7]}}, rb1, rb0}
                                                   : {16'h0, rb1, rb0};
            2'b11: mem_read_data = {rb3, rb2, rb1, rb0};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        case (mem_mem_write)
            2'b01: dmem[mem_addr[9:0]] <= mem_write_data[7:0];
            2'b10: begin
                dmem[mem_addr[9:0]]         <= mem_write_data[7:0];
                dmem[mem_addr[9:0] + 10'd1] <= mem_write_data[15:8];
            end
            2'b11: begin
                dmem[mem_addr[9:0]]         <= mem_write_data[7:0];
                dmem[mem_addr[9:0] + 10'd1] <= mem_write_data[15:8];
                dmem[mem_addr[9:0] + 10'd2] <= mem_write_data[23:16];
                dmem[mem_addr[9:0] + 10'd3] <= mem_write_data[31:24];
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic        dbg;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] last_rdata [2];
    int          total = 0;
    int          bad   = 0;

    // Expected response for a granted request; rdata holds when not a legal read.
    function automatic rsp_t exp_rsp(input logic is_dbg, input logic [31:0] addr,
                                     input logic [2:0] rd, input logic [1:0] wr,
                                     input logic [31:0] data);
        rsp_t r;
        int   nb;
        logic err;
        nb  = (rd[1:0] == 2'b01 || (rd[1:0] == 2'b00 && wr == 2'b01)) ? 1 :
              (rd[1:0] == 2'b10 || (rd[1:0] == 2'b00 && wr == 2'b10)) ? 2 :
              (rd[1:0] == 2'b11 || (rd[1:0] == 2'b00 && wr == 2'b11)) ? 4 : 0;
        err = (rd != 3'b000) && (wr != 2'b00);
        if (nb != 0) begin
            if (nb == 2 && addr[0]) err = 1'b1;
            if (nb == 4 && addr[1:0] != 2'b00) err = 1'b1;
            if (longint'(addr) + longint'(nb) > 64'd1024) err = 1'b1;
        end
        r.dbg    = is_dbg;
        r.err    = err;
        r.rvalid = !err && (rd[1:0] != 2'b00);
        r.rdata  = r.rvalid ? data : last_rdata[is_dbg];
        last_rdata[is_dbg] = r.rdata;
        return r;
    endfunction

    function automatic rsp_t observe(input logic is_dbg);
        rsp_t r;
        r.dbg    = is_dbg;
        r.rvalid = is_dbg ? dbg_bus.rvalid : core_bus.rvalid;
        r.err    = is_dbg ? dbg_bus.err    : core_bus.err;
        r.rdata  = is_dbg ? dbg_bus.rdata  : core_bus.rdata;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] rd, input logic [1:0] wr);
        core_bus.req = req; core_bus.addr = addr; core_bus.wdata = wdata;
        core_bus.mem_read = rd; core_bus.mem_write = wr;
    endtask

    task automatic set_dbg(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] rd, input logic [1:0] wr);
        dbg_bus.req = req; dbg_bus.addr = addr; dbg_bus.wdata = wdata;
        dbg_bus.mem_read = rd; dbg_bus.mem_write = wr;
    endtask

    task automatic test_reset();
        logic [31:0] obs [10];
        string       nm  [10];
        rst = 1'b1;
        set_core(0, 0, 0, 3'b000, 2'b00);
        set_dbg(0, 0, 0, 3'b000, 2'b00);
        for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
        tick();
        tick();
        obs[0] = 32'(core_bus.rvalid); nm[0] = "core_rvalid";
        obs[1] = 32'(core_bus.err);    nm[1] = "core_err";
        obs[2] = core_bus.rdata;       nm[2] = "core_rdata";
        obs[3] = 32'(dbg_bus.rvalid);  nm[3] = "dbg_rvalid";
        obs[4] = 32'(dbg_bus.err);     nm[4] = "dbg_err";
        obs[5] = dbg_bus.rdata;        nm[5] = "dbg_rdata";
        obs[6] = 32'(core_bus.gnt);    nm[6] = "core_gnt";
        obs[7] = 32'(dbg_bus.gnt);     nm[7] = "dbg_gnt";
        obs[8] = {27'h0, mem_mem_read, mem_mem_write}; nm[8] = "mem_ctrl";
        obs[9] = 32'(dut.starve_q);    nm[9] = "starve_cnt";
        for (int i = 0; i < 10; i++) begin
            total++;
            if (obs[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset %s: got %h want 0", nm[i], obs[i]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_word_read();
        rsp_t e, o, oth;
        dmem[16] <= 8'hEF; dmem[17] <= 8'hBE; dmem[18] <= 8'hAD; dmem[19] <= 8'hDE;
        set_core(1, 32'h10, 0, 3'b011, 2'b00);
        #1;
        total++;
        if (core_bus.gnt !== 1'b1 || dbg_bus.gnt !== 1'b0 || mem_addr !== 32'h10 ||
            mem_mem_read !== 3'b011) begin
            bad++;
            $display("FAIL word_read grant: gnt=%b/%b addr=%h rd=%b want 1/0 00000010 011",
                     core_bus.gnt, dbg_bus.gnt, mem_addr, mem_mem_read);
        end
        sb.push_back(exp_rsp(0, 32'h10, 3'b011, 2'b00, 32'hDEADBEEF));
        tick();
        set_core(0, 0, 0, 3'b000, 2'b00);
        e = sb.pop_front(); o = observe(e.dbg); oth = observe(!e.dbg);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL word_read rsp: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     o.rvalid, o.err, o.rdata, e.rvalid, e.err, e.rdata);
        end
        total++;
        if (oth.rvalid !== 1'b0 || oth.err !== 1'b0) begin
            bad++;
            $display("FAIL word_read idle port: got v=%b e=%b want 0 0", oth.rvalid, oth.err);
        end
    endtask

    task automatic test_starvation();
        logic exp_dbg [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rsp_t e, o, oth;
        dmem[64] <= 8'h44; dmem[65] <= 8'h33; dmem[66] <= 8'h22; dmem[67] <= 8'h11;
        set_core(1, 32'h10, 0, 3'b011, 2'b00);
        set_dbg(1, 32'h40, 0, 3'b011, 2'b00);
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (core_bus.gnt !== !exp_dbg[c] || dbg_bus.gnt !== exp_dbg[c]) begin
                bad++;
                $display("FAIL starve cycle %0d gnt: got core=%b dbg=%b want core=%b dbg=%b",
                         c, core_bus.gnt, dbg_bus.gnt, !exp_dbg[c], exp_dbg[c]);
            end
            if (exp_dbg[c]) sb.push_back(exp_rsp(1, 32'h40, 3'b011, 2'b00, 32'h11223344));
            else            sb.push_back(exp_rsp(0, 32'h10, 3'b011, 2'b00, 32'hDEADBEEF));
            tick();
            e = sb.pop_front(); o = observe(e.dbg); oth = observe(!e.dbg);
            total++;
            if (o !== e || oth.rvalid !== 1'b0 || oth.err !== 1'b0) begin
                bad++;
                $display("FAIL starve cycle %0d rsp: got v=%b e=%b d=%h other v=%b want v=%b e=%b d=%h other v=0",
                         c, o.rvalid, o.err, o.rdata, oth.rvalid, e.rvalid, e.err, e.rdata);
            end
        end
        set_core(0, 0, 0, 3'b000, 2'b00);
        set_dbg(0, 0, 0, 3'b000, 2'b00);
    endtask

    task automatic test_misaligned_store();
        rsp_t e, o;
        dmem[32] <= 8'h5A; dmem[33] <= 8'h5A; dmem[34] <= 8'hA5; dmem[35] <= 8'hA5;
        set_dbg(1, 32'h21, 32'h1234, 3'b000, 2'b10);
        #1;
        total++;
        if (dbg_bus.gnt !== 1'b1 || mem_mem_write !== 2'b00 || mem_mem_read !== 3'b000) begin
            bad++;
            $display("FAIL misaligned grant: gnt=%b wr=%b rd=%b want 1 00 000",
                     dbg_bus.gnt, mem_mem_write, mem_mem_read);
        end
        sb.push_back(exp_rsp(1, 32'h21, 3'b000, 2'b10, 32'h0));
        tick();
        set_dbg(0, 0, 0, 3'b000, 2'b00);
        e = sb.pop_front(); o = observe(e.dbg);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL misaligned rsp: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     o.rvalid, o.err, o.rdata, e.rvalid, e.err, e.rdata);
        end
        set_core(1, 32'h20, 0, 3'b011, 2'b00);
        #1;
        sb.push_back(exp_rsp(0, 32'h20, 3'b011, 2'b00, 32'hA5A55A5A));
        tick();
        set_core(0, 0, 0, 3'b000, 2'b00);
        e = sb.pop_front(); o = observe(e.dbg);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL misaligned readback: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     o.rvalid, o.err, o.rdata, e.rvalid, e.err, e.rdata);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ca [9] = '{32'h3FF, 32'h3FE, 32'h3FC, 32'h3FF, 32'h3FE,
                                32'h3FF, 32'h400, 32'h10, 32'h10};
        logic [2:0]  cr [9] = '{3'b101, 3'b011, 3'b011, 3'b001, 3'b110,
                                3'b010, 3'b001, 3'b011, 3'b000};
        logic [1:0]  cw [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b00, 2'b11, 2'b00};
        logic [31:0] cd [9] = '{32'hFFFFFF80, 32'h0, 32'h80223344, 32'h00000080, 32'hFFFF8022,
                                32'h0, 32'h0, 32'h0, 32'h0};
        rsp_t e, o, oth;
        logic [2:0] want_rd;
        dmem[1020] <= 8'h44; dmem[1021] <= 8'h33; dmem[1022] <= 8'h22; dmem[1023] <= 8'h80;
        #1;
        for (int c = 0; c < 9; c++) begin
            set_core(1, ca[c], 32'hCAFEF00D, cr[c], cw[c]);
            #1;
            e = exp_rsp(0, ca[c], cr[c], cw[c], cd[c]);
            want_rd = e.err ? 3'b000 : cr[c];
            total++;
            if (core_bus.gnt !== 1'b1 || mem_mem_read !== want_rd ||
                mem_mem_write !== (e.err ? 2'b00 : cw[c])) begin
                bad++;
                $display("FAIL boundary case %0d fwd: gnt=%b rd=%b wr=%b want 1 %b %b",
                         c, core_bus.gnt, mem_mem_read, mem_mem_write, want_rd,
                         e.err ? 2'b00 : cw[c]);
            end
            sb.push_back(e);
            tick();
            e = sb.pop_front(); o = observe(e.dbg); oth = observe(!e.dbg);
            total++;
            if (o !== e || oth.rvalid !== 1'b0 || oth.err !== 1'b0) begin
                bad++;
                $display("FAIL boundary case %0d rsp: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         c, o.rvalid, o.err, o.rdata, e.rvalid, e.err, e.rdata);
            end
        end
        set_core(0, 0, 0, 3'b000, 2'b00);
    endtask

    task automatic test_reset_mid();
        rsp_t e, o;
        set_core(1, 32'h10, 0, 3'b011, 2'b00);
        set_dbg(1, 32'h40, 0, 3'b011, 2'b00);
        #1;
        sb.push_back(exp_rsp(0, 32'h10, 3'b011, 2'b00, 32'hDEADBEEF));
        tick();
        e = sb.pop_front(); o = observe(e.dbg);
        total++;
        if (o !== e || dut.starve_q !== 4'd1) begin
            bad++;
            $display("FAIL rst_mid pre: got v=%b d=%h cnt=%0d want v=%b d=%h cnt=1",
                     o.rvalid, o.rdata, dut.starve_q, e.rvalid, e.rdata);
        end
        #1;
        total++;
        if (core_bus.gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid gnt: got %b want 1", core_bus.gnt);
        end
        rst = 1'b1;
        tick();
        total++;
        if (core_bus.rvalid !== 1'b0 || dbg_bus.rvalid !== 1'b0 || dut.starve_q !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid dropped: got core_rv=%b dbg_rv=%b cnt=%0d want 0 0 0",
                     core_bus.rvalid, dbg_bus.rvalid, dut.starve_q);
        end
        set_core(0, 0, 0, 3'b000, 2'b00);
        set_dbg(0, 0, 0, 3'b000, 2'b00);
        rst = 1'b0;
        #1;
        total++;
        if (mem_mem_read !== 3'b000 || mem_mem_write !== 2'b00 || mem_addr !== 32'h0 ||
            core_bus.gnt !== 1'b0 || dbg_bus.gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid idle: rd=%b wr=%b addr=%h gnt=%b/%b want 000 00 0 0/0",
                     mem_mem_read, mem_mem_write, mem_addr, core_bus.gnt, dbg_bus.gnt);
        end
        tick();
        total++;
        if (core_bus.rvalid !== 1'b0 || core_bus.err !== 1'b0 ||
            dbg_bus.rvalid !== 1'b0 || dbg_bus.err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid after: core v=%b e=%b dbg v=%b e=%b want all 0",
                     core_bus.rvalid, core_bus.err, dbg_bus.rvalid, dbg_bus.err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
        test_reset();
        test_word_read();
        test_starvation();
        test_misaligned_store();
        test_boundary();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
